regbank_alu_ctrl: RTL and testbench
===================================

Name: regbank_alu_ctrl

Overview:
- Sequencing stage directly upstream of the add/sub ALU in the Multi_Register datapath.
- Holds a 4-entry register bank and accepts one instruction at a time over a valid/ready handshake.
- Drives the external combinational ALU operands and op select, captures the ALU result, and writes it back to the destination register.
- Produces a one-cycle done pulse with the written value.

Parameters:
- N, 8, data width of registers, immediate and ALU operands.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction present on opcode/rd/ra/rb/imm.
- instr_ready  output  1  block can accept an instruction.
- opcode  input  2  00 LOAD, 01 ADD, 10 SUB, 11 MOV.
- rd  input  2  destination register index.
- ra  input  2  first source register index.
- rb  input  2  second source register index (ADD/SUB only).
- imm  input  N  immediate operand (LOAD only).
- alu_in1  output  N  ALU first operand (registered).
- alu_in2  output  N  ALU second operand (registered).
- alu_addsub  output  1  ALU op select: 1 = add, 0 = subtract (registered).
- alu_out  input  N  combinational ALU result.
- done  output  1  one-cycle pulse: writeback occurring this cycle.
- result  output  N  value being written; valid while done=1.
- busy  output  1  high in any state other than IDLE.
- dbg_addr  input  2  debug read index.
- dbg_data  output  N  combinational read of register dbg_addr.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; R0..R3=0.
  - alu_in1=0, alu_in2=0, alu_addsub=1.
  - result=0, done=0, busy=0.
  - instr_ready is 1 once state is IDLE.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On clock edge E0 with instr_valid=1, latch opcode/rd/ra/rb/imm; go to READ. Without instr_valid, stay in IDLE.
  - READ: load operand registers; go to EXEC at edge E1.
    - LOAD: in1=imm, in2=0, addsub=1.
    - ADD: in1=R[ra], in2=R[rb], addsub=1.
    - SUB: in1=R[ra], in2=R[rb], addsub=0.
    - MOV: in1=R[ra], in2=0, addsub=1.
  - EXEC: ALU operands are stable for the full cycle. At edge E2, capture alu_out into result; go to WB.
  - WB: done=1 for exactly this cycle. At edge E3, write R[rd]=result; go to IDLE.
- Timing:
  - Latency is 3 cycles from accept edge to writeback edge.
  - Next accept is possible at E4 at the earliest, so throughput is 1 instruction per 4 cycles.
- Handshake:
  - instr_ready=0 in READ/EXEC/WB.
  - instr_valid during busy is ignored; the instruction fields are not re-sampled.
- Arithmetic:
  - Modulo 2^N, as provided by the ALU; no carry or borrow is retained.
  - Example: 200+100 = 44; 100-200 = 156.
- Hazards:
  - Sources are read in READ, so rd==ra or rd==rb uses the pre-write value.
  - An instruction accepted at E4 sees the value written at E3.
- Other rules:
  - alu_in1/alu_in2/alu_addsub hold their values after WB until the next READ.
  - dbg_data reflects a write on the cycle after the write edge.
- Reset mid-operation: abandons the instruction. No register write, no done pulse, and the bank is cleared.

Optional Feature:
- Macro: REGBANK_ALU_FLAGS_EN.
- With the macro defined:
  - Adds output ports flag_z (1) and flag_n (1).
  - Both are updated at the WB writeback edge: flag_z=(result==0), flag_n=result[N-1].
  - Both hold their values until the next writeback; both reset to 0.
- Without the macro: neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Reset release, then LOAD R1,200 then LOAD R2,100 -> done pulses 3 cycles after each accept; dbg R1=200, R2=100; R0=R3=0.
- ADD R3=R1+R2 -> alu_addsub=1 in EXEC, alu_in1=200, alu_in2=100; result=44 with done; R3=44.
- SUB R0=R2-R1 -> alu_addsub=0 in EXEC; result=156; R0=156. MOV R2=R3 -> R2=44.
- Hold instr_valid=1 with LOAD R1,5 continuously -> instr_ready=0 for 3 cycles after accept; exactly one accept every 4 cycles; no duplicate done.
- ADD R1=R1+R1 with R1=5, back-to-back with ADD R2=R1+R0 (R0=0) -> R1=10, then R2=10 (new value seen).
- Assert rst_n=0 during EXEC of LOAD R3,77 -> no done; R3=0; instr_ready=1 after release. With REGBANK_ALU_FLAGS_EN: SUB R0=R1-R1 -> flag_z=1, flag_n=0; LOAD R0,128 -> flag_z=0, flag_n=1.

Source files
------------

// File: rtl/regbank_alu_ctrl.sv
// Four-entry register bank sequencer feeding an external add/sub ALU (IDLE/READ/EXEC/WB).
// Optional zero/negative flags when REGBANK_ALU_FLAGS_EN is defined.
module regbank_alu_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [1:0]   opcode,
  input  logic [1:0]   rd,
  input  logic [1:0]   ra,
  input  logic [1:0]   rb,
  input  logic [N-1:0] imm,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  output logic         alu_addsub,
  input  logic [N-1:0] alu_out,
  output logic         done,
  output logic [N-1:0] result,
  output logic         busy,
  input  logic [1:0]   dbg_addr,
  output logic [N-1:0] dbg_data
`ifdef REGBANK_ALU_FLAGS_EN
  ,
  output logic         flag_z,
  output logic         flag_n
`endif
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MOV  = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     op_reg, rd_reg, ra_reg, rb_reg;
  logic [N-1:0]   imm_reg;
  logic [N-1:0]   bank_reg [4];
  logic           accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        accept      = instr_valid;
        if (instr_valid) state_next = READ;
      end
      READ: state_next = EXEC;
      EXEC: state_next = WB;
      WB: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction fields are sampled only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= OP_LOAD;
      rd_reg  <= '0;
      ra_reg  <= '0;
      rb_reg  <= '0;
      imm_reg <= '0;
    end else if (accept) begin
      op_reg  <= opcode;
      rd_reg  <= rd;
      ra_reg  <= ra;
      rb_reg  <= rb;
      imm_reg <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_addsub <= 1'b1;
    end else if (state_reg == READ) begin
      case (op_reg)
        OP_LOAD: begin alu_in1 <= imm_reg;          alu_in2 <= '0;               alu_addsub <= 1'b1; end
        OP_ADD:  begin alu_in1 <= bank_reg[ra_reg]; alu_in2 <= bank_reg[rb_reg]; alu_addsub <= 1'b1; end
        OP_SUB:  begin alu_in1 <= bank_reg[ra_reg]; alu_in2 <= bank_reg[rb_reg]; alu_addsub <= 1'b0; end
        default: begin alu_in1 <= bank_reg[ra_reg]; alu_in2 <= '0;               alu_addsub <= 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 result <= '0;
    else if (state_reg == EXEC) result <= alu_out;
  end

  // One always_ff per bank entry so each has its own write enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          bank_reg[gi] <= '0;
        else if (state_reg == WB && rd_reg == 2'(gi))
          bank_reg[gi] <= result;
      end
    end
  endgenerate

  assign dbg_data = bank_reg[dbg_addr];

`ifdef REGBANK_ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state_reg == WB) begin
      flag_z <= (result == '0);
      flag_n <= result[N-1];
    end
  end
`endif

endmodule

// File: tb/tb_regbank_alu_ctrl.sv
// Directed bench for regbank_alu_ctrl with a behavioural add/sub ALU attached.
module tb_regbank_alu_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [1:0]   opcode = '0, rd = '0, ra = '0, rb = '0;
  logic [N-1:0] imm = '0;
  logic [N-1:0] alu_in1, alu_in2, alu_out;
  logic         alu_addsub;
  logic         done, busy;
  logic [N-1:0] result;
  logic [1:0]   dbg_addr = '0;
  logic [N-1:0] dbg_data;
`ifdef REGBANK_ALU_FLAGS_EN
  logic         flag_z, flag_n;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Captured by run_instr for the calling test to compare.
  logic         obs_ready0;
  logic [N-1:0] obs_in1, obs_in2, obs_result;
  logic         obs_addsub;
  int           obs_done_at, obs_done_cnt, obs_ready_low;

  always #5 clk = ~clk;

  assign alu_out = alu_addsub ? (alu_in1 + alu_in2) : (alu_in1 - alu_in2);

  regbank_alu_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_addsub(alu_addsub), .alu_out(alu_out),
    .done(done), .result(result), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef REGBANK_ALU_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  // Called on a negedge with the DUT idle; returns on the negedge after writeback.
  task automatic run_instr(input logic [1:0] op, input logic [1:0] d, input logic [1:0] a,
                           input logic [1:0] b, input logic [N-1:0] im);
    obs_ready0    = instr_ready;
    obs_done_at   = -1;
    obs_done_cnt  = 0;
    obs_ready_low = 0;
    obs_result    = '0;
    opcode = op; rd = d; ra = a; rb = b; imm = im;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        obs_in1 = alu_in1; obs_in2 = alu_in2; obs_addsub = alu_addsub;
      end
      if (c <= 3 && !instr_ready) obs_ready_low++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_at < 0) begin obs_done_at = c; obs_result = result; end
      end
      if (c < 4) @(negedge clk);
    end
    $display("txn op=%0d rd=%0d ra=%0d rb=%0d imm=%0d -> in1=%0d in2=%0d addsub=%0d result=%0d done_at=%0d",
             op, d, a, b, im, obs_in1, obs_in2, obs_addsub, obs_result, obs_done_at);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (result !== 8'd0) begin n_err++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_cmp++; if ({alu_in1, alu_in2, alu_addsub} !== 17'h00001) begin
      n_err++; $display("FAIL reset_alu got=%0d/%0d/%b exp=0/0/1", alu_in1, alu_in2, alu_addsub); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL reset_bank R%0d got=%0d exp=0", i, dbg_data); end
    end
  endtask

  task automatic test_load;
    run_instr(2'b00, 2'd1, 2'd0, 2'd0, 8'd200);
    n_cmp++; if (obs_ready0 !== 1'b1) begin n_err++; $display("FAIL load1_ready got=%b exp=1", obs_ready0); end
    n_cmp++; if (obs_done_at != 3 || obs_done_cnt != 1) begin
      n_err++; $display("FAIL load1_done_timing got=at%0d/cnt%0d exp=at3/cnt1", obs_done_at, obs_done_cnt); end
    n_cmp++; if (obs_result !== 8'd200) begin n_err++; $display("FAIL load1_result got=%0d exp=200", obs_result); end
    n_cmp++; if (obs_ready_low != 3) begin n_err++; $display("FAIL load1_ready_low got=%0d exp=3", obs_ready_low); end
    run_instr(2'b00, 2'd2, 2'd0, 2'd0, 8'd100);
    n_cmp++; if (obs_done_at != 3 || obs_result !== 8'd100) begin
      n_err++; $display("FAIL load2 got=at%0d/%0d exp=at3/100", obs_done_at, obs_result); end
    dbg_addr = 2'd1; #1;
    n_cmp++; if (dbg_data !== 8'd200) begin n_err++; $display("FAIL load_R1 got=%0d exp=200", dbg_data); end
    dbg_addr = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'd100) begin n_err++; $display("FAIL load_R2 got=%0d exp=100", dbg_data); end
    dbg_addr = 2'd0; #1;
    n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL load_R0 got=%0d exp=0", dbg_data); end
    dbg_addr = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL load_R3 got=%0d exp=0", dbg_data); end
  endtask

  task automatic test_add;
    run_instr(2'b01, 2'd3, 2'd1, 2'd2, 8'd0);
    n_cmp++; if ({obs_in1, obs_in2, obs_addsub} !== {8'd200, 8'd100, 1'b1}) begin
      n_err++; $display("FAIL add_operands got=%0d/%0d/%b exp=200/100/1", obs_in1, obs_in2, obs_addsub); end
    n_cmp++; if (obs_result !== 8'd44 || obs_done_at != 3) begin
      n_err++; $display("FAIL add_result got=%0d@%0d exp=44@3", obs_result, obs_done_at); end
    dbg_addr = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'd44) begin n_err++; $display("FAIL add_R3 got=%0d exp=44", dbg_data); end
  endtask

  task automatic test_sub_mov;
    run_instr(2'b10, 2'd0, 2'd2, 2'd1, 8'd0);
    n_cmp++; if ({obs_in1, obs_in2, obs_addsub} !== {8'd100, 8'd200, 1'b0}) begin
      n_err++; $display("FAIL sub_operands got=%0d/%0d/%b exp=100/200/0", obs_in1, obs_in2, obs_addsub); end
    n_cmp++; if (obs_result !== 8'd156) begin n_err++; $display("FAIL sub_result got=%0d exp=156", obs_result); end
    dbg_addr = 2'd0; #1;
    n_cmp++; if (dbg_data !== 8'd156) begin n_err++; $display("FAIL sub_R0 got=%0d exp=156", dbg_data); end
    run_instr(2'b11, 2'd2, 2'd3, 2'd1, 8'd99);
    n_cmp++; if ({obs_in1, obs_in2, obs_addsub} !== {8'd44, 8'd0, 1'b1}) begin
      n_err++; $display("FAIL mov_operands got=%0d/%0d/%b exp=44/0/1", obs_in1, obs_in2, obs_addsub); end
    dbg_addr = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'd44) begin n_err++; $display("FAIL mov_R2 got=%0d exp=44", dbg_data); end
    @(negedge clk);
    n_cmp++; if (alu_in1 !== 8'd44 || alu_addsub !== 1'b1) begin
      n_err++; $display("FAIL alu_hold got=%0d/%b exp=44/1", alu_in1, alu_addsub); end
  endtask

  task automatic test_hold_valid;
    int accepts = 0;
    int dones = 0;
    opcode = 2'b00; rd = 2'd1; ra = 2'd0; rb = 2'd0; imm = 8'd5;
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) accepts++;
      if (done) dones++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    $display("txn hold_valid LOAD R1,5 accepts=%0d dones=%0d", accepts, dones);
    n_cmp++; if (accepts != 3) begin n_err++; $display("FAIL hold_accepts got=%0d exp=3", accepts); end
    n_cmp++; if (dones != 3) begin n_err++; $display("FAIL hold_dones got=%0d exp=3", dones); end
    dbg_addr = 2'd1; #1;
    n_cmp++; if (dbg_data !== 8'd5) begin n_err++; $display("FAIL hold_R1 got=%0d exp=5", dbg_data); end
  endtask

  task automatic test_back_to_back;
    run_instr(2'b00, 2'd0, 2'd0, 2'd0, 8'd0);
    run_instr(2'b01, 2'd1, 2'd1, 2'd1, 8'd0);
    n_cmp++; if (obs_result !== 8'd10) begin n_err++; $display("FAIL b2b_first got=%0d exp=10", obs_result); end
    run_instr(2'b01, 2'd2, 2'd1, 2'd0, 8'd0);
    n_cmp++; if (obs_ready0 !== 1'b1 || obs_in1 !== 8'd10) begin
      n_err++; $display("FAIL b2b_forward got=ready%b/in1=%0d exp=ready1/in1=10", obs_ready0, obs_in1); end
    dbg_addr = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'd10) begin n_err++; $display("FAIL b2b_R2 got=%0d exp=10", dbg_data); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    opcode = 2'b00; rd = 2'd3; ra = 2'd0; rb = 2'd0; imm = 8'd77;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_async got=done%b/busy%b exp=0/0", done, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    $display("txn reset_mid LOAD R3,77 dones=%0d", dones);
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midrst_done got=%0d exp=0", dones); end
    dbg_addr = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL midrst_R3 got=%0d exp=0", dbg_data); end
    dbg_addr = 2'd1; #1;
    n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL midrst_R1 got=%0d exp=0", dbg_data); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", instr_ready); end
  endtask

`ifdef REGBANK_ALU_FLAGS_EN
  task automatic test_flags;
    run_instr(2'b10, 2'd0, 2'd1, 2'd1, 8'd0);
    n_cmp++; if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
      n_err++; $display("FAIL flags_zero got=z%b/n%b exp=z1/n0", flag_z, flag_n); end
    run_instr(2'b00, 2'd0, 2'd0, 2'd0, 8'd128);
    n_cmp++; if (flag_z !== 1'b0 || flag_n !== 1'b1) begin
      n_err++; $display("FAIL flags_neg got=z%b/n%b exp=z0/n1", flag_z, flag_n); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_load;
    test_add;
    test_sub_mov;
    test_hold_valid;
    test_back_to_back;
    test_reset_mid;
`ifdef REGBANK_ALU_FLAGS_EN
    test_flags;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
